// File: rtl/bk_operand_recover_if.sv
// Request/response bundle for the digit-serial operand recovery block.
// The producer of operands is the master; the recovery block is the slave.
interface bk_operand_recover_if #(
    parameter int WIDTH = 12
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH:0]   in_sum;
    logic [WIDTH-1:0] in_a;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_b;
    logic             out_err;

    modport master (
        output in_valid, in_sum, in_a, out_ready,
        input  in_ready, out_valid, out_b, out_err
    );

    modport slave (
        input  in_valid, in_sum, in_a, out_ready,
        output in_ready, out_valid, out_b, out_err
    );
endinterface

// File: rtl/bk_operand_recover.sv
// Digit-serial subtractor recovering B = SUM - A from an adder result,
// flagging SUM/A pairs that no WIDTH-bit B could have produced.
module bk_operand_recover #(
    parameter int WIDTH = 12,
    parameter int DIGIT = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    bk_operand_recover_if.slave bus
);
    localparam int N     = WIDTH / DIGIT;
    localparam int CNT_W = (N > 1) ? $clog2(N) : 1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N - 1);

    generate
        if (WIDTH % DIGIT != 0) begin : g_bad_digit
            $error("bk_operand_recover: WIDTH must be a multiple of DIGIT");
        end
    endgenerate

    logic [1:0]       state_q, state_d;
    logic [WIDTH:0]   sum_q, sum_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic [WIDTH-1:0] out_b_q, out_b_d;
    logic             out_err_q, out_err_d;
    logic             borrow_q, borrow_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic [DIGIT-1:0] sum_digit;
    logic [DIGIT-1:0] a_digit;
    logic [DIGIT:0]   diff;

    always_comb begin
        sum_digit = sum_q[cnt_q*DIGIT +: DIGIT];
        a_digit   = a_q[cnt_q*DIGIT +: DIGIT];
        // One extra bit wide so the top bit of diff is the outgoing borrow.
        diff      = {1'b0, sum_digit} - {1'b0, a_digit} - {{DIGIT{1'b0}}, borrow_q};

        state_d   = state_q;
        sum_d     = sum_q;
        a_d       = a_q;
        res_d     = res_q;
        out_b_d   = out_b_q;
        out_err_d = out_err_q;
        borrow_d  = borrow_q;
        cnt_d     = cnt_q;

        case (state_q)
            S_IDLE: begin
                if (bus.in_valid) begin
                    state_d  = S_RUN;
                    sum_d    = bus.in_sum;
                    a_d      = bus.in_a;
                    borrow_d = 1'b0;
                    cnt_d    = '0;
                end
            end
            S_RUN: begin
                res_d[cnt_q*DIGIT +: DIGIT] = diff[DIGIT-1:0];
                borrow_d = diff[DIGIT];
                cnt_d    = cnt_q + 1'b1;
                if (cnt_q == CNT_LAST) begin
                    // Result is published only on completion so out_b never shows a partial value.
                    state_d   = S_DONE;
                    out_b_d   = res_d;
                    out_err_d = sum_q[WIDTH] ^ diff[DIGIT];
                end
            end
            S_DONE: begin
                if (bus.out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            sum_q     <= '0;
            a_q       <= '0;
            res_q     <= '0;
            out_b_q   <= '0;
            out_err_q <= 1'b0;
            borrow_q  <= 1'b0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            sum_q     <= sum_d;
            a_q       <= a_d;
            res_q     <= res_d;
            out_b_q   <= out_b_d;
            out_err_q <= out_err_d;
            borrow_q  <= borrow_d;
            cnt_q     <= cnt_d;
        end
    end

    assign bus.in_ready  = (state_q == S_IDLE);
    assign bus.out_valid = (state_q == S_DONE);
    assign bus.out_b     = out_b_q;
    assign bus.out_err   = out_err_q;
endmodule

// File: tb/tb_bk_operand_recover.sv
// Drives a DIGIT=2 and a DIGIT=3 instance in lockstep and compares both
// against plain integer arithmetic for B = SUM - A and the range error.
module tb_bk_operand_recover;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    bk_operand_recover_if #(.WIDTH(12)) bus2 ();
    bk_operand_recover_if #(.WIDTH(12)) bus3 ();

    bk_operand_recover #(.WIDTH(12), .DIGIT(2)) dut2 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus2.slave)
    );

    bk_operand_recover #(.WIDTH(12), .DIGIT(3)) dut3 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus3.slave)
    );

    localparam int LAT2 = 12 / 2;
    localparam int LAT3 = 12 / 3;

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic set_in(input logic v, input logic [12:0] s, input logic [11:0] a);
        bus2.in_valid = v; bus2.in_sum = s; bus2.in_a = a;
        bus3.in_valid = v; bus3.in_sum = s; bus3.in_a = a;
    endtask

    task automatic set_ready(input logic r);
        bus2.out_ready = r;
        bus3.out_ready = r;
    endtask

    // Issue one operation at a negedge, collect both results, then handshake.
    task automatic do_op(input logic [12:0] s, input logic [11:0] a, input int hold, input bit junk);
        int         d;
        logic [11:0] eb;
        logic       eerr;
        int         lat2;
        int         lat3;
        d    = int'(s) - int'(a);
        eb   = 12'(d);
        eerr = (d < 0) || (d > 4095);
        $display("op sum=0x%04h a=0x%03h -> expect b=0x%03h err=%0d", s, a, eb, eerr);

        check("in_ready2_idle", bus2.in_ready, 1);
        check("in_ready3_idle", bus3.in_ready, 1);
        set_ready(1'b0);
        set_in(1'b1, s, a);
        @(posedge clk);
        @(negedge clk);
        set_in(1'b0, 13'h0, 12'h0);

        lat2 = 0;
        lat3 = 0;
        for (int k = 1; k <= 20 && (lat2 == 0 || lat3 == 0); k++) begin
            if (junk) set_in(1'b1, 13'($urandom_range(0, 8191)), 12'($urandom_range(0, 4095)));
            @(posedge clk);
            @(negedge clk);
            if (lat2 == 0 && bus2.out_valid === 1'b1) lat2 = k;
            if (lat3 == 0 && bus3.out_valid === 1'b1) lat3 = k;
        end
        set_in(1'b0, 13'h0, 12'h0);

        check("latency2", lat2, LAT2);
        check("latency3", lat3, LAT3);
        check("out_b2", bus2.out_b, eb);
        check("out_err2", bus2.out_err, eerr);
        check("out_b3", bus3.out_b, eb);
        check("out_err3", bus3.out_err, eerr);

        for (int h = 0; h < hold; h++) begin
            @(posedge clk);
            @(negedge clk);
            check("hold_valid2", bus2.out_valid, 1);
            check("hold_b2", bus2.out_b, eb);
            check("hold_err2", bus2.out_err, eerr);
            check("hold_in_ready2", bus2.in_ready, 0);
            check("hold_valid3", bus3.out_valid, 1);
            check("hold_b3", bus3.out_b, eb);
        end

        set_ready(1'b1);
        @(posedge clk);
        @(negedge clk);
        set_ready(1'b0);
        check("post_in_ready2", bus2.in_ready, 1);
        check("post_out_valid2", bus2.out_valid, 0);
        check("post_b2_held", bus2.out_b, eb);
        check("post_in_ready3", bus3.in_ready, 1);
        check("post_out_valid3", bus3.out_valid, 0);
    endtask

    initial begin
        logic [11:0] ra;
        logic [11:0] rb;

        set_in(1'b0, 13'h0, 12'h0);
        set_ready(1'b0);
        repeat (2) @(negedge clk);
        check("rst_in_ready", bus2.in_ready, 1);
        check("rst_out_valid", bus2.out_valid, 0);
        check("rst_out_b", bus2.out_b, 0);
        check("rst_out_err", bus2.out_err, 0);
        check("rst_out_valid3", bus3.out_valid, 0);
        rst_n = 1'b1;

        do_op(13'h0005, 12'h003, 0, 1'b0);
        do_op(13'h1FFE, 12'hFFF, 0, 1'b0);
        do_op(13'h0000, 12'h000, 0, 1'b0);
        do_op(13'h0003, 12'h005, 0, 1'b0);
        do_op(13'h1000, 12'h000, 0, 1'b0);
        do_op(13'h08AB, 12'h123, 10, 1'b1);

        // Abort mid-RUN: result register must clear without waiting for a clock.
        set_in(1'b1, 13'h07FF, 12'h123);
        @(posedge clk);
        @(negedge clk);
        set_in(1'b0, 13'h0, 12'h0);
        @(posedge clk);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        $display("reset asserted in third RUN cycle");
        check("abort_out_valid2", bus2.out_valid, 0);
        check("abort_in_ready2", bus2.in_ready, 1);
        check("abort_out_b2", bus2.out_b, 0);
        check("abort_out_err2", bus2.out_err, 0);
        check("abort_out_valid3", bus3.out_valid, 0);
        check("abort_in_ready3", bus3.in_ready, 1);
        @(negedge clk);
        rst_n = 1'b1;
        do_op(13'h000A, 12'h004, 0, 1'b0);

        for (int i = 0; i < 1000; i++) begin
            ra = 12'($urandom_range(0, 4095));
            rb = 12'($urandom_range(0, 4095));
            do_op({1'b0, ra} + {1'b0, rb}, ra, 0, 1'b0);
        end
        for (int i = 0; i < 300; i++) begin
            ra = 12'($urandom_range(1, 4095));
            do_op(13'($urandom_range(0, int'(ra) - 1)), ra, 0, 1'b0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
